store_buffer: RTL and testbench

- Posted-write buffer between the MEM-stage load/store path and the single-port word data memory (256 words, combinational read, registered write, shared address port).
- Stores are queued in a small FIFO and drained to memory in cycles when the CPU is not loading.
- Loads are forwarded from the youngest matching queued store, otherwise passed straight to memory.
- CPU-side signalling is unchanged except for an added stall output.

---
 rtl/store_buffer_if.sv | 26 ++
 rtl/store_buffer.sv | 97 +++++++++
 tb/tb_store_buffer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// CPU MEM-stage and data-memory signals seen by the store buffer.
// slave = store buffer side; master = CPU/memory environment side.
interface store_buffer_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        stall;
  logic        empty;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_Address;
  logic [31:0] mem_Write_data;
  logic [31:0] mem_Read_data;

  modport master (
    output MemRead, MemWrite, Address, Write_data, mem_Read_data,
    input  Read_data, stall, empty, mem_MemRead, mem_MemWrite, mem_Address, mem_Write_data
  );

  modport slave (
    input  MemRead, MemWrite, Address, Write_data, mem_Read_data,
    output Read_data, stall, empty, mem_MemRead, mem_MemWrite, mem_Address, mem_Write_data
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of a single-port data memory; stores drain one per free port cycle, loads forward/pass through combinationally.
// Stalls the CPU when full, on a forced drain, or (STORE_BUFFER_FORWARD_EN undefined) on a load that hits a queued store.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_BITS  = 8,
  parameter int MAX_STARVE = 8
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [ADDR_BITS-1:0] idx_q [DEPTH];
  logic [31:0]          dat_q [DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;

  logic [ADDR_BITS-1:0] ld_idx;
  logic [PW-1:0]        pos;
  logic                 hit;
  logic [31:0]          hit_dat;
  logic                 load, force_ld, hit_stall, drain, full_st, accept, serve;

  assign ld_idx = sb.Address[ADDR_BITS+1:2];

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_dat = '0;
    pos     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = head_q + PW'(i);
      if ((CW'(i) < count_q) && (idx_q[pos] == ld_idx)) begin
        hit     = 1'b1;
        hit_dat = dat_q[pos];
      end
    end
  end

  always_comb begin
    load     = sb.MemRead && !sb.MemWrite;
    force_ld = rst && sb.MemRead && (starve_q == SW'(MAX_STARVE));
`ifdef STORE_BUFFER_FORWARD_EN
    hit_stall = 1'b0;
`else
    hit_stall = rst && load && hit && !force_ld;
`endif
    // A raw MemRead holds the port even for a read+write violation.
    drain   = rst && (count_q != '0) && (!sb.MemRead || force_ld || hit_stall);
    full_st = rst && sb.MemWrite && (count_q == CW'(DEPTH));
    accept  = rst && sb.MemWrite && !full_st && !force_ld;
    serve   = rst && load && !force_ld && !hit_stall;

    sb.stall          = full_st || force_ld || hit_stall;
    sb.empty          = (count_q == '0) || !rst;
    sb.mem_MemWrite   = drain;
    sb.mem_MemRead    = serve && !hit;
    sb.mem_Write_data = drain ? dat_q[head_q] : 32'h0;
    sb.mem_Address    = drain ? {{(30-ADDR_BITS){1'b0}}, idx_q[head_q], 2'b00} : sb.Address;
    sb.Read_data      = !serve ? 32'h0 : (hit ? hit_dat : sb.mem_Read_data);

    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(accept);
    count_d = count_q + CW'(accept) - CW'(drain);
    if (drain || (count_q == '0))
      starve_d = '0;
    else if (sb.MemRead && !force_ld)
      starve_d = starve_q + SW'(1);
    else
      starve_d = starve_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q[tail_q] <= ld_idx;
      dat_q[tail_q] <= sb.Write_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed vector bench for store_buffer with a behavioural 256-word data memory.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if bus();
  store_buffer #(.DEPTH(4), .ADDR_BITS(8), .MAX_STARVE(8)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  logic [31:0] mem [256];
  assign bus.mem_Read_data = mem[bus.mem_Address[9:2]];
  always @(posedge clk)
    if (bus.mem_MemWrite) mem[bus.mem_Address[9:2]] <= bus.mem_Write_data;

  typedef struct {
    logic [31:0] rd, wr, addr, wdat;
    logic [31:0] e_stall, e_empty, e_mwr, e_maddr, e_mwd, e_mrd, chk_rd, e_rdat;
  } vec_t;

  vec_t vt[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] initv(int i);
    return 32'hDEAD0000 | 32'(i);
  endfunction

  function automatic vec_t mk(input logic [31:0] rd, wr, a, d, st, em, mw, ma, md, mr, cr, rdat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdat = d;
    v.e_stall = st; v.e_empty = em; v.e_mwr = mw; v.e_maddr = ma;
    v.e_mwd = md; v.e_mrd = mr; v.chk_rd = cr; v.e_rdat = rdat;
    return v;
  endfunction

  task automatic chk(string tag, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // Drive at posedge+1, compare at the falling edge, then advance one cycle.
  task automatic apply(vec_t v, string tag);
    bus.MemRead    = v.rd[0];
    bus.MemWrite   = v.wr[0];
    bus.Address    = v.addr;
    bus.Write_data = v.wdat;
    #4;
    chk(tag, "stall", 32'(bus.stall), v.e_stall);
    chk(tag, "empty", 32'(bus.empty), v.e_empty);
    chk(tag, "mem_MemWrite", 32'(bus.mem_MemWrite), v.e_mwr);
    chk(tag, "mem_MemRead", 32'(bus.mem_MemRead), v.e_mrd);
    if (v.e_mwr[0] || v.e_mrd[0]) chk(tag, "mem_Address", bus.mem_Address, v.e_maddr);
    if (v.e_mwr[0]) chk(tag, "mem_Write_data", bus.mem_Write_data, v.e_mwd);
    if (v.chk_rd[0]) chk(tag, "Read_data", bus.Read_data, v.e_rdat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = initv(i);
    rst = 1'b0;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Address = '0; bus.Write_data = '0;

    // Reset held for two edges.
    @(posedge clk);
    #4;
    chk("rst", "empty", 32'(bus.empty), 1);
    chk("rst", "stall", 32'(bus.stall), 0);
    chk("rst", "mem_MemWrite", 32'(bus.mem_MemWrite), 0);
    chk("rst", "Read_data", bus.Read_data, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // rd wr addr wdat | stall empty mwr maddr mwd mrd chk_rd rdat
    vt.push_back(mk(0, 0, 0, 0,                 0, 1, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 'h40, 'h11111111,     0, 1, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,                 0, 0, 1, 'h40, 'h11111111, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,                 0, 1, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 'h80, 'hA,            0, 1, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 'h80, 'hB,            0, 0, 1, 'h80, 'hA, 0, 1, 0));
`ifdef STORE_BUFFER_FORWARD_EN
    vt.push_back(mk(1, 0, 'h80, 0,              0, 0, 0, 0, 0, 0, 1, 'hB));
    vt.push_back(mk(0, 0, 0, 0,                 0, 0, 1, 'h80, 'hB, 0, 1, 0));
    vt.push_back(mk(1, 0, 'h80, 0,              0, 1, 0, 'h80, 0, 1, 1, 'hB));
`else
    vt.push_back(mk(1, 0, 'h80, 0,              1, 0, 1, 'h80, 'hB, 0, 0, 0));
    vt.push_back(mk(1, 0, 'h80, 0,              0, 1, 0, 'h80, 0, 1, 1, 'hB));
`endif
    // Read+write together counts as a store and keeps the port busy, filling the buffer.
    vt.push_back(mk(1, 1, 'h100, 1,             0, 1, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 'h104, 2,             0, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 'h100, 3,             0, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 'h10C, 4,             0, 0, 0, 0, 0, 0, 1, 0));
`ifdef STORE_BUFFER_FORWARD_EN
    vt.push_back(mk(1, 0, 'h100, 0,             0, 0, 0, 0, 0, 0, 1, 3));
`endif
    vt.push_back(mk(0, 1, 'h110, 5,             1, 0, 1, 'h100, 1, 0, 1, 0));
    vt.push_back(mk(0, 1, 'h110, 5,             0, 0, 1, 'h104, 2, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,                 0, 0, 1, 'h100, 3, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,                 0, 0, 1, 'h10C, 4, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,                 0, 0, 1, 'h110, 5, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0,                 0, 1, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("v%0d", i));
    chk("order", "mem[0x100]", mem[64], 3);
    chk("order", "mem[0x110]", mem[68], 5);

    // Starvation: eight loads served, ninth forces the drain, then completes.
    apply(mk(0, 1, 'h200, 'h77, 0, 1, 0, 0, 0, 0, 1, 0), "frc_st");
    for (int k = 0; k < 8; k++)
      apply(mk(1, 0, 'h300 + 4*k, 0, 0, 0, 0, 'h300 + 4*k, 0, 1, 1, initv(192 + k)),
            $sformatf("frc_ld%0d", k));
    apply(mk(1, 0, 'h320, 0, 1, 0, 1, 'h200, 'h77, 0, 0, 0), "frc_force");
    apply(mk(1, 0, 'h320, 0, 0, 1, 0, 'h320, 0, 1, 1, initv(200)), "frc_done");
    chk("frc", "mem[0x200]", mem[128], 'h77);

    // Queued stores discarded by a one-cycle reset.
    apply(mk(1, 1, 'h3A0, 'hC1, 0, 1, 0, 0, 0, 0, 1, 0), "rd_st0");
    apply(mk(1, 1, 'h3A4, 'hC2, 0, 0, 0, 0, 0, 0, 1, 0), "rd_st1");
    apply(mk(1, 1, 'h3A8, 'hC3, 0, 0, 0, 0, 0, 0, 1, 0), "rd_st2");
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    rst = 1'b0;
    #4;
    chk("rd_rst", "mem_MemWrite", 32'(bus.mem_MemWrite), 0);
    chk("rd_rst", "empty", 32'(bus.empty), 1);
    chk("rd_rst", "stall", 32'(bus.stall), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "rd_idle0");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "rd_idle1");
    apply(mk(1, 0, 'h3A4, 0, 0, 1, 0, 'h3A4, 0, 1, 1, initv(233)), "rd_load");
    chk("rd", "mem[0x3A0]", mem[232], initv(232));
    chk("rd", "mem[0x3A8]", mem[234], initv(234));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
